seg7_scan_ctrl: RTL and testbench

//   Time-multiplexed N-digit seven-segment display controller. Holds one 4-bit hex value per

---
 rtl/seg7_scan_ctrl_if.sv | 21 ++
 rtl/seg7_scan_ctrl.sv | 74 +++++++
 tb/tb_seg7_scan_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: write port, digit enables and display pin bundle for seg7_scan_ctrl
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int AW = $clog2(NUM_DIGITS);
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [3:0]            wr_data;
    logic [NUM_DIGITS-1:0] digit_en;
    logic [6:0]            segments;
    logic [NUM_DIGITS-1:0] anode;
    logic                  frame_tick;
    modport master (
        output wr_en, wr_addr, wr_data, digit_en,
        input  segments, anode, frame_tick
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, digit_en,
        output segments, anode, frame_tick
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed N-digit seven-segment scan controller with hex register file
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input logic             clk,
    input logic             rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int AW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [3:0]            digits [NUM_DIGITS];
    logic [CW-1:0]         cnt;
    logic [AW-1:0]         idx;
    logic [NUM_DIGITS-1:0] blank;
    logic [6:0]            seg_next;
    logic                  wr_hit;
    logic                  dwell_end;

    assign wr_hit    = bus.wr_en && 32'(bus.wr_addr) < NUM_DIGITS;
    assign dwell_end = cnt == CNT_LAST;
    assign seg_next  = blank[idx] ? 7'h7F : SEG_LUT[digits[idx]];

`ifdef SEG7_LZ_BLANK_EN
    logic zero_run;
    // blank[k] is set while digit k and every digit above it hold zero; digit 0 always shows
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && digits[k] == 4'd0;
            blank[k] = zero_run;
        end
    end
`else
    assign blank = '0;
`endif

    // register file write port; addresses beyond the last digit are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'd0;
        end else if (wr_hit) begin
            digits[bus.wr_addr] <= bus.wr_data;
        end
    end

    // refresh divider, scan index and registered pin drive from the pre-advance index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            idx            <= '0;
            bus.segments   <= 7'h7F;
            bus.anode      <= '1;
            bus.frame_tick <= 1'b0;
        end else begin
            cnt            <= dwell_end ? '0 : cnt + 1'b1;
            idx            <= dwell_end ? (idx == IDX_LAST ? '0 : idx + 1'b1) : idx;
            bus.frame_tick <= dwell_end && idx == IDX_LAST;
            bus.segments   <= seg_next;
            bus.anode      <= bus.digit_en[idx] ? ~(NUM_DIGITS'(1) << idx) : '1;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed bench for seg7_scan_ctrl with NUM_DIGITS=8, REFRESH_DIV=4
module tb_seg7_scan_ctrl;
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [6:0] exp_seg [8];
    logic       seen;

    seg7_scan_ctrl_if #(.NUM_DIGITS(8)) bus ();
    seg7_scan_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        adv(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_tick();
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            adv(1);
            seen = bus.frame_tick;
        end
        chk("frame_tick_seen", {31'd0, seen}, 32'd1);
    endtask

    // expects to start at the negedge right after a wrap (or reset release)
    task automatic run_frame(input string name, input logic [7:0] en);
        for (int i = 0; i < 32; i++) begin
            int s;
            logic [7:0] exp_an;
            s = i / 4;
            exp_an = en[s] ? ~(8'd1 << s) : 8'hFF;
            adv(1);
            chk($sformatf("%s anode c%0d", name, i), bus.anode, exp_an);
            chk($sformatf("%s seg c%0d", name, i), bus.segments, exp_seg[s]);
            chk($sformatf("%s tick c%0d", name, i), bus.frame_tick, i == 31);
        end
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.digit_en = 8'hFF;
        // async reset with no clock edge in between
        #3 rst = 1'b1;
        #1;
        chk("rst_async seg", bus.segments, 7'h7F);
        chk("rst_async anode", bus.anode, 8'hFF);
        chk("rst_async tick", bus.frame_tick, 1'b0);
        adv(2);
        chk("rst_hold seg", bus.segments, 7'h7F);
        chk("rst_hold anode", bus.anode, 8'hFF);
        rst = 1'b0;
        adv(1);
        chk("first anode", bus.anode, 8'hFE);
        chk("first seg", bus.segments, 7'b1000000);
        chk("first tick", bus.frame_tick, 1'b0);
        // digits 0..7 hold 0..7, full scan
        for (int d = 0; d < 8; d++) wr(3'(d), 4'(d));
        for (int d = 0; d < 8; d++) exp_seg[d] = SEG[d];
        wait_tick();
        run_frame("scan", 8'hFF);
        // digit 2 disabled: anode off, other slots unchanged
        bus.digit_en = 8'b1111_1011;
        run_frame("en_mask", 8'b1111_1011);
        bus.digit_en = 8'hFF;
        // write the digit being scanned: one-cycle latency to the pins
        adv(21);
        chk("live pre anode", bus.anode, 8'hDF);
        chk("live pre seg", bus.segments, 7'b0010010);
        wr(3'd5, 4'hE);
        chk("live wr_edge seg", bus.segments, 7'b0010010);
        adv(1);
        chk("live next seg", bus.segments, 7'b0000110);
        chk("live next anode", bus.anode, 8'hDF);
        exp_seg[5] = SEG[14];
        wait_tick();
        run_frame("after_live", 8'hFF);
        // leading-zero pattern: only digit 2 = A
        for (int d = 0; d < 8; d++) wr(3'(d), d == 2 ? 4'hA : 4'h0);
        for (int d = 0; d < 8; d++) exp_seg[d] = SEG[0];
        exp_seg[2] = SEG[10];
`ifdef SEG7_LZ_BLANK_EN
        for (int d = 3; d < 8; d++) exp_seg[d] = 7'h7F;
`endif
        wait_tick();
        run_frame("lz", 8'hFF);
        // reset in the middle of slot 6
        adv(25);
        chk("pre_rst anode", bus.anode, 8'hBF);
        chk("pre_rst seg", bus.segments, exp_seg[6]);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst seg", bus.segments, 7'h7F);
        chk("mid_rst anode", bus.anode, 8'hFF);
        chk("mid_rst tick", bus.frame_tick, 1'b0);
        adv(3);
        chk("rst3 anode", bus.anode, 8'hFF);
        rst = 1'b0;
        for (int d = 0; d < 8; d++) exp_seg[d] = SEG[0];
`ifdef SEG7_LZ_BLANK_EN
        for (int d = 1; d < 8; d++) exp_seg[d] = 7'h7F;
`endif
        run_frame("post_rst", 8'hFF);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
